// File: rtl/subterranean_pkg.sv
// -----------------------------------------------------------------------------
// subterranean_pkg
// Shared definitions for the Subterranean round wrapper.
//   SUBTERRANEAN_WIDTH : permutation state width in bits (fixed by the algorithm)
//   fsm_state_t        : wrapper control states (IDLE, DONE, OUT)
// -----------------------------------------------------------------------------
package subterranean_pkg;

   localparam int SUBTERRANEAN_WIDTH = 257;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DONE = 2'd1,
      OUT  = 2'd2
   } fsm_state_t;

endpackage

// File: rtl/subterranean_round.sv
// -----------------------------------------------------------------------------
// subterranean_round
// One Subterranean round as pure combinational logic. All index arithmetic is
// modulo 257 and resolved at elaboration time, so the result is plain wiring
// plus one level of AND/XOR for chi and a 3-input XOR for theta.
// Ports:
//   state_in  : 257-bit state before the round
//   state_out : 257-bit state after chi, iota, theta and pi
// -----------------------------------------------------------------------------
module subterranean_round
   import subterranean_pkg::*;
(
   input  logic [SUBTERRANEAN_WIDTH-1:0] state_in,
   output logic [SUBTERRANEAN_WIDTH-1:0] state_out
);

   localparam int N = SUBTERRANEAN_WIDTH;

   logic [N-1:0] chi_iota;
   logic [N-1:0] theta;

   genvar gi;

   // chi with iota folded in: only bit 0 receives the round constant.
   generate
      for (gi = 0; gi < N; gi++) begin : g_chi
         localparam int I1 = (gi + 1) % N;
         localparam int I2 = (gi + 2) % N;
         localparam logic RC = (gi == 0) ? 1'b1 : 1'b0;
         assign chi_iota[gi] = state_in[gi] ^ (~state_in[I1] & state_in[I2]) ^ RC;
      end
   endgenerate

   generate
      for (gi = 0; gi < N; gi++) begin : g_theta
         localparam int I3 = (gi + 3) % N;
         localparam int I8 = (gi + 8) % N;
         assign theta[gi] = chi_iota[gi] ^ chi_iota[I3] ^ chi_iota[I8];
      end
   endgenerate

   // pi: output bit i is taken from position 12*i mod 257.
   generate
      for (gi = 0; gi < N; gi++) begin : g_pi
         localparam int SRC = (12 * gi) % N;
         assign state_out[gi] = theta[SRC];
      end
   endgenerate

endmodule

// File: rtl/subterranean_round_with_communication.sv
// -----------------------------------------------------------------------------
// subterranean_round_with_communication
// Holds a 257-bit Subterranean state, loads it bit-serially (LSB first),
// applies one round on start and unloads the result bit-serially (LSB first).
// Ports:
//   clk            : rising-edge clock
//   arstn          : asynchronous active-low reset
//   start          : run one round on the held state (honoured only when idle)
//   data_in_valid  : serial input bit valid
//   data_in        : serial input bit
//   data_in_ready  : block accepts input bits (idle)
//   data_out       : serial output bit, always state bit 0
//   data_out_valid : data_out carries a result bit
//   data_out_ready : consumer accepts the current output bit
//   finish         : one-cycle pulse in the cycle after start is sampled
//   core_free      : block is idle
// -----------------------------------------------------------------------------
module subterranean_round_with_communication
   import subterranean_pkg::*;
#(
   parameter int WIDTH = SUBTERRANEAN_WIDTH
)
(
   input  logic clk,
   input  logic arstn,
   input  logic start,
   input  logic data_in_valid,
   input  logic data_out_ready,
   input  logic data_in,
   output logic data_out,
   output logic data_out_valid,
   output logic data_in_ready,
   output logic finish,
   output logic core_free
);

   localparam logic [8:0] LAST_BIT = 9'(WIDTH - 1);

   fsm_state_t         fsm_reg;
   logic [WIDTH-1:0]   state_reg;
   logic [WIDTH-1:0]   round_out;
   logic [8:0]         cnt_reg;
   logic               finish_reg;
   logic               out_valid_reg;
   logic               in_ready_reg;
   logic               free_reg;

   subterranean_round u_round (
      .state_in  (state_reg),
      .state_out (round_out)
   );

   // Output flags are registered alongside the state transition so that each
   // flag is a direct flop output with its reset value applied asynchronously.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         fsm_reg       <= IDLE;
         state_reg     <= '0;
         cnt_reg       <= '0;
         finish_reg    <= 1'b0;
         out_valid_reg <= 1'b0;
         in_ready_reg  <= 1'b1;
         free_reg      <= 1'b1;
      end else begin
         case (fsm_reg)
            IDLE: begin
               // start wins over a simultaneous input bit, which is dropped
               if (start) begin
                  state_reg    <= round_out;
                  fsm_reg      <= DONE;
                  finish_reg   <= 1'b1;
                  in_ready_reg <= 1'b0;
                  free_reg     <= 1'b0;
               end else if (data_in_valid) begin
                  state_reg <= {data_in, state_reg[WIDTH-1:1]};
               end
            end
            DONE: begin
               fsm_reg       <= OUT;
               cnt_reg       <= '0;
               finish_reg    <= 1'b0;
               out_valid_reg <= 1'b1;
            end
            OUT: begin
               if (data_out_ready) begin
                  state_reg <= {1'b0, state_reg[WIDTH-1:1]};
                  if (cnt_reg == LAST_BIT) begin
                     fsm_reg       <= IDLE;
                     cnt_reg       <= '0;
                     out_valid_reg <= 1'b0;
                     in_ready_reg  <= 1'b1;
                     free_reg      <= 1'b1;
                  end else begin
                     cnt_reg <= cnt_reg + 9'd1;
                  end
               end
            end
            default: begin
               fsm_reg       <= IDLE;
               cnt_reg       <= '0;
               finish_reg    <= 1'b0;
               out_valid_reg <= 1'b0;
               in_ready_reg  <= 1'b1;
               free_reg      <= 1'b1;
            end
         endcase
      end
   end

   assign data_out       = state_reg[0];
   assign data_out_valid = out_valid_reg;
   assign data_in_ready  = in_ready_reg;
   assign finish         = finish_reg;
   assign core_free      = free_reg;

endmodule

// File: tb/tb_subterranean_round_with_communication.sv
// -----------------------------------------------------------------------------
// Bench for subterranean_round_with_communication: serial load, one round,
// serial unload, compared against a round model computed from the
// algorithm's definition with plain array arithmetic.
// -----------------------------------------------------------------------------
module tb_subterranean_round_with_communication;

   logic clk = 1'b0;
   logic arstn = 1'b0;
   logic start = 1'b0;
   logic data_in_valid = 1'b0;
   logic data_out_ready = 1'b0;
   logic data_in = 1'b0;
   logic data_out;
   logic data_out_valid;
   logic data_in_ready;
   logic finish;
   logic core_free;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   subterranean_round_with_communication dut (
      .clk            (clk),
      .arstn          (arstn),
      .start          (start),
      .data_in_valid  (data_in_valid),
      .data_out_ready (data_out_ready),
      .data_in        (data_in),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .data_in_ready  (data_in_ready),
      .finish         (finish),
      .core_free      (core_free)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [256:0] got, input logic [256:0] exp);
      total++;
      assert (got === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [256:0] ref_round(input logic [256:0] s);
      bit a [257];
      bit b [257];
      logic [256:0] o;
      for (int i = 0; i < 257; i++)
         a[i] = s[i] ^ (~s[(i + 1) % 257] & s[(i + 2) % 257]);
      a[0] = ~a[0];
      for (int i = 0; i < 257; i++)
         b[i] = a[i] ^ a[(i + 3) % 257] ^ a[(i + 8) % 257];
      for (int i = 0; i < 257; i++)
         o[i] = b[(12 * i) % 257];
      return o;
   endfunction

   function automatic logic [256:0] rand_vec();
      logic [256:0] v;
      for (int i = 0; i < 8; i++) v[i * 32 +: 32] = $urandom;
      v[256] = 1'($urandom_range(0, 1));
      return v;
   endfunction

   // Shift the first n bits of vec into the block, LSB first.
   task automatic load(input logic [256:0] vec, input int n);
      for (int i = 0; i < n; i++) begin
         data_in       = vec[i];
         data_in_valid = 1'b1;
         step();
      end
      data_in_valid = 1'b0;
      data_in       = 1'b0;
   endtask

   // Pulse start, check the finish pulse, then collect 257 output bits.
   task automatic round_and_unload(input bit stall, input bit noise, input bit drop_bit,
                                   output logic [256:0] res, output int cycles);
      int beats;
      res = '0;
      start = 1'b1;
      if (drop_bit) begin
         data_in_valid = 1'b1;
         data_in       = 1'b1;
      end
      step();
      start = 1'b0;
      data_in_valid = 1'b0;
      data_in = 1'b0;
      cycles = 1;
      check("finish_hi", 257'(finish), 257'(1));
      check("core_busy", 257'(core_free), 257'(0));
      if (noise) begin
         start = 1'b1;
         data_in_valid = 1'b1;
         data_in = 1'($urandom_range(0, 1));
      end
      step();
      cycles++;
      check("finish_one_cycle", 257'(finish), 257'(0));
      beats = 0;
      while (beats < 257 && cycles < 4000) begin
         data_out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         if (noise) begin
            start = 1'($urandom_range(0, 1));
            data_in_valid = 1'($urandom_range(0, 1));
            data_in = 1'($urandom_range(0, 1));
         end
         if (data_out_valid && data_out_ready) begin
            res[beats] = data_out;
            beats++;
         end
         step();
         cycles++;
      end
      data_out_ready = 1'b0;
      start = 1'b0;
      data_in_valid = 1'b0;
      data_in = 1'b0;
      check("beats", 257'(beats), 257'(257));
      check("idle_after_unload", {254'b0, data_in_ready, core_free, data_out_valid}, 257'b110);
   endtask

   initial begin
      logic [256:0] vec;
      logic [256:0] res;
      logic [256:0] res2;
      logic [256:0] exp;
      int cycles;
      int first_cycles;

      // Reset
      arstn = 1'b0;
      step();
      step();
      check("reset_flags", {253'b0, data_in_ready, core_free, finish, data_out_valid}, 257'b1100);
      check("reset_data_out", 257'(data_out), 257'(0));
      arstn = 1'b1;
      step();
      $display("reset released");

      // Zero state: only bits 0, 64, 85 set
      load('0, 257);
      round_and_unload(1'b0, 1'b0, 1'b0, res, cycles);
      exp = '0;
      exp[0] = 1'b1;
      exp[64] = 1'b1;
      exp[85] = 1'b1;
      check("zero_state", res, exp);
      $display("zero state: result %h", res);

      // 100 random vectors, no stall
      first_cycles = 0;
      for (int k = 0; k < 100; k++) begin
         vec = rand_vec();
         load(vec, 257);
         round_and_unload(1'b0, 1'b0, 1'b0, res, cycles);
         check("random_vec", res, ref_round(vec));
         if (k == 0) first_cycles = cycles;
         else check("op_time", 257'(cycles), 257'(first_cycles));
         $display("vector %0d: in %h out %h cycles %0d", k, vec, res, cycles);
      end

      // Backpressure plus ignored start/data_in during DONE/OUT
      for (int k = 0; k < 4; k++) begin
         vec = rand_vec();
         load(vec, 257);
         round_and_unload(1'b0, 1'b0, 1'b0, res, cycles);
         load(vec, 257);
         round_and_unload(1'b1, 1'b1, 1'b0, res2, cycles);
         check("stall_noise_vs_clean", res2, res);
         check("stall_noise_ref", res2, ref_round(vec));
         $display("stall run %0d: out %h cycles %0d", k, res2, cycles);
      end

      // start with data_in_valid in IDLE: the 257th bit is dropped.
      // State is zero after an unload, so 256 loaded bits sit at positions 1..256.
      vec = rand_vec();
      load(vec, 256);
      round_and_unload(1'b0, 1'b0, 1'b1, res, cycles);
      check("start_drops_bit", res, ref_round({vec[255:0], 1'b0}));
      $display("start+data_in: out %h", res);

      // Asynchronous reset after 100 output bits
      vec = rand_vec();
      load(vec, 257);
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      data_out_ready = 1'b1;
      for (int i = 0; i < 100; i++) step();
      data_out_ready = 1'b0;
      check("pre_reset_in_out", 257'(data_out_valid), 257'(1));
      arstn = 1'b0;
      #1;
      check("async_reset_flags", {253'b0, data_in_ready, core_free, finish, data_out_valid}, 257'b1100);
      check("async_reset_data_out", 257'(data_out), 257'(0));
      step();
      step();
      arstn = 1'b1;
      step();
      vec = rand_vec();
      load(vec, 257);
      round_and_unload(1'b0, 1'b0, 1'b0, res, cycles);
      check("after_reset_vec", res, ref_round(vec));
      $display("after mid-OUT reset: out %h", res);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
